mips_ram: RTL and testbench
===========================

# mips_ram

Single-port 256 x 32-bit synchronous-write, asynchronous-read RAM with a shared bidirectional data bus. It serves as the data/instruction memory of the MIPS datapath. Access is gated by chip-select, write-enable and output-enable. An asynchronous active-low reset clears the whole array.

## Interface
- ADDR_WIDTH, 8: word address width.
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- DEPTH, 2**ADDR_WIDTH (256): number of words; not independently overridable.
- clk  input  1  clock; writes occur on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- addr  input  ADDR_WIDTH  word address.
- data  inout  DATA_WIDTH  bidirectional data bus. Driven by the RAM on reads; driven by the master on writes.
- cs  input  1  chip select, active-high.
- we  input  1  write enable, active-high.
- oe  input  1  output enable, active-high.
- be  input  DATA_WIDTH/8  byte write enables, active-high. Present only with RAM_BYTE_WRITE_EN (see Configuration).

## Operation
- **Read:** when cs=1, oe=1, we=0 and rst_n=1, data = mem[addr]. The read path is combinational; no clock is required.
- **Bus release:** in every other case the RAM drives data to all-Z (high impedance).
- **Write:** on posedge clk with rst_n=1, cs=1 and we=1, mem[addr] <= data (the value the master drives on the bus).
- **Write priority:** we=1 overrides oe. The RAM never drives the bus while we=1, so there is no bus contention.
- **Deselected:** cs=0 ignores we and oe. No write takes place and the bus is Z.
- **Reset:** rst_n=0 immediately clears all DEPTH words to 0x00000000 and forces data to Z.
- **During reset:** writes are ignored while rst_n=0.
- **Release:** after rst_n rises, the first write can occur at the next rising clk edge.
- **Address range:** full-range decode, so every addr value maps to a distinct word. No aliasing or out-of-range case exists.
- **X/Z on address:** if addr contains X or Z during a read, data returns X. If addr contains X or Z during a write, no word is modified.

## Timing
- Read latency is zero cycles (combinational from addr, cs, oe, we and rst_n).
- Write takes effect at the sampling posedge clk. A read of the same address reflects the new value immediately after that edge.
- A write followed by a read of the same address in the next cycle returns the written value.
- Back-to-back writes can occur on every cycle.
- Reset assertion is asynchronous and takes effect without a clock edge. Deassertion does not need to be synchronized inside the RAM; the system reset synchronizer provides clean release.
- No handshake, wait states or ready signal.

## Configuration
- Macro: RAM_BYTE_WRITE_EN.
- **Defined:**
  - The be port exists.
  - On a qualifying write, only the bytes with be[i]=1 are updated: data[8i+7:8i] is written to mem[addr][8i+7:8i].
  - Bytes with be[i]=0 keep their contents.
  - be=0 on a qualifying write modifies nothing.
  - Reads ignore be and always return the full word.
- **Undefined:**
  - The be port is absent.
  - Every qualifying write updates the full word.

## Test plan
- **Reset read-back:** assert rst_n=0, release it, then read addr 0..19 with cs=1, oe=1, we=0. Every read must return 0x00000000.
- **Write/read:** write 0xDEADBEEF to addr 0x05 and 0x12345678 to addr 0xFF. Read both back and get the same values. addr 0x06 must still read 0x00000000.
- **Bus control:**
  - cs=0 with oe=1: data must be Z.
  - cs=1, oe=0: data must be Z.
  - cs=1, we=1, oe=1: the RAM does not drive the bus, and the word is written at the clock edge.
- **Deselected write:** with cs=0 and we=1, drive 0xA5A5A5A5 at addr 0x10 and clock. A subsequent read of addr 0x10 must return its prior value.
- **Reset mid-operation:** after writing nonzero values, pulse rst_n low between clock edges.
  - data must go Z immediately.
  - A write attempted while rst_n=0 is ignored.
  - After release, all addresses read 0x00000000.
- **RAM_BYTE_WRITE_EN:** write 0x11223344 with be=4'b1111, then write 0xAABBCCDD with be=4'b0101 to the same address. The read must return 0x11BB33DD.

Source files
------------

// File: rtl/mips_ram.sv
// mips_ram: 256x32 single-port RAM, synchronous write, combinational read, shared tri-state data bus.
// Optional macro RAM_BYTE_WRITE_EN adds the be port and per-byte write masking.
module mips_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    cs,
    input  logic                    we,
    input  logic                    oe,
`ifdef RAM_BYTE_WRITE_EN
    input  logic [DATA_WIDTH/8-1:0] be,
`endif
    inout  wire  [DATA_WIDTH-1:0]   data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Drive the bus only for a selected, non-write read outside reset; release it otherwise
    assign data = (rst_n && cs && oe && !we) ? mem[addr] : {DATA_WIDTH{1'bz}};

    // Asynchronous clear of the whole array; qualifying writes capture the bus at the clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (cs && we) begin
`ifdef RAM_BYTE_WRITE_EN
            for (int b = 0; b < DATA_WIDTH / 8; b++)
                if (be[b]) mem[addr][8*b +: 8] <= data[8*b +: 8];
`else
            mem[addr] <= data;
`endif
        end
    end
endmodule

// File: tb/tb_mips_ram.sv
// tb_mips_ram: randomized scoreboard bench for mips_ram; a pullup on the bus makes a released bus read all ones.
module tb_mips_ram;
    localparam logic [31:0] REL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = '0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic        oe = 1'b0;
    logic [3:0]  be = 4'hF;
    logic        drv_en = 1'b0;
    logic [31:0] drv = '0;
    wire  [31:0] data;

    assign data = drv_en ? drv : 32'hzzzz_zzzz;
    for (genvar g = 0; g < 32; g++) begin : g_pu
        pullup (data[g]);
    end

    mips_ram dut (
        .clk  (clk),
        .rst_n(rst_n),
        .addr (addr),
        .cs   (cs),
        .we   (we),
        .oe   (oe),
`ifdef RAM_BYTE_WRITE_EN
        .be   (be),
`endif
        .data (data)
    );

    always #5 clk = ~clk;

    logic [31:0] model [256];
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        chk = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Monitor: bus is stable mid-cycle, compare against the oldest expectation
    always @(negedge clk) begin
        if (chk) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow: bus %h with no expected value queued", data);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string nm = name_q.pop_front();
                if (data !== e) begin
                    n_bad++;
                    $display("FAIL %s: addr %h got %h expected %h", nm, addr, data, e);
                end
            end
        end
    end

    // One bus cycle: apply inputs, queue the bus value the spec predicts, then apply the write rule to the model
    task automatic op(input logic c, input logic w, input logic o, input logic [7:0] a,
                      input logic d, input logic [31:0] wd, input logic [3:0] b, input string nm);
        logic [31:0] e;
        logic [3:0]  m;
        @(posedge clk);
        #1;
        cs = c; we = w; oe = o; addr = a; drv_en = d; drv = wd; be = b;
        if (d) e = wd;
        else if (rst_n && c && o && !w) e = model[a];
        else e = REL;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk = 1'b1;
`ifdef RAM_BYTE_WRITE_EN
        m = b;
`else
        m = 4'hF;
`endif
        if (rst_n && c && w)
            for (int k = 0; k < 4; k++)
                if (m[k]) model[a][8*k +: 8] = d ? wd[8*k +: 8] : 8'hFF;
    endtask

    task automatic rd(input logic [7:0] a, input string nm);
        op(1'b1, 1'b0, 1'b1, a, 1'b0, 32'h0, 4'h0, nm);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] b, input string nm);
        op(1'b1, 1'b1, 1'b0, a, 1'b1, wd, b, nm);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) rd(8'(i), "reset_readback");
        wr(8'h05, 32'hDEAD_BEEF, 4'hF, "wr05_bus");
        wr(8'hFF, 32'h1234_5678, 4'hF, "wrFF_bus");
        rd(8'h05, "rd05");
        rd(8'hFF, "rdFF");
        rd(8'h06, "rd06_untouched");
        op(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 32'h0, 4'h0, "cs0_oe1_release");
        op(1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 32'h0, 4'h0, "oe0_release");
        op(1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 32'hCAFE_F00D, 4'hF, "we_oe_driven");
        rd(8'h20, "we_oe_readback");
        op(1'b1, 1'b1, 1'b1, 8'h21, 1'b0, 32'h0, 4'hF, "we_oe_no_drive");
        rd(8'h21, "we_oe_pulled_readback");
        op(1'b0, 1'b1, 1'b0, 8'h10, 1'b1, 32'hA5A5_A5A5, 4'hF, "desel_write_bus");
        rd(8'h10, "desel_write_readback");
`ifdef RAM_BYTE_WRITE_EN
        wr(8'h30, 32'h1122_3344, 4'b1111, "be_full");
        wr(8'h30, 32'hAABB_CCDD, 4'b0101, "be_partial");
        rd(8'h30, "be_merge");
        wr(8'h30, 32'h5566_7788, 4'b0000, "be_none");
        rd(8'h30, "be_none_readback");
`endif
        for (int i = 0; i < 300; i++) begin
            automatic logic [7:0]  a  = 8'($urandom_range(0, 255));
            automatic logic [31:0] wd = $urandom;
            automatic logic [3:0]  b  = 4'($urandom);
            if (wd == REL) wd = 32'h0;
            case ($urandom_range(0, 4))
                0, 1: wr(a, wd, b, "rand_write");
                2:    rd(a, "rand_read");
                3:    op(1'b0, 1'($urandom), 1'($urandom), a, 1'b0, 32'h0, b, "rand_desel");
                default: op(1'b1, 1'b0, 1'b0, a, 1'b0, 32'h0, b, "rand_oe0");
            endcase
        end
        wr(8'h40, 32'h0BAD_F00D, 4'hF, "pre_reset_write");
        rd(8'h40, "pre_reset_read");
        rst_n = 1'b0;
        exp_q[exp_q.size()-1] = REL;
        name_q[name_q.size()-1] = "reset_release_bus";
        wr(8'h40, 32'h7777_7777, 4'hF, "write_in_reset_bus");
        rd(8'h40, "read_in_reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = '0;
        for (int i = 0; i < 256; i++) rd(8'(i), "post_reset_clear");
        @(negedge clk);
        #1 chk = 1'b0;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
